// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/writeback sequencing.
// Strobes are decoded from the current state so handshakes act in-cycle.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_FENCE, C_SYSTEM, C_ILLEGAL
    } cls_t;

    state_t      r_state;
    cls_t        r_cls;
    logic        r_illegal;
    logic [31:0] r_count;

    cls_t        w_dec;
    logic        w_imem_req;
    logic        w_ir_we;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_rf_we;
    logic        w_pc_we;
    logic [1:0]  w_wb_sel;
    logic [1:0]  w_pc_sel;
    logic        w_retire;

    always_comb begin
        w_dec = C_ILLEGAL;
        case (opcode)
            7'b0110011, 7'b0010011: w_dec = C_ALU;
            7'b0110111: w_dec = C_LUI;
            7'b0010111: w_dec = C_AUIPC;
            7'b0000011: w_dec = C_LOAD;
            7'b0100011: w_dec = C_STORE;
            7'b1100011: w_dec = C_BRANCH;
            7'b1101111: w_dec = C_JAL;
            7'b1100111: w_dec = C_JALR;
            7'b0001111: w_dec = C_FENCE;
            7'b1110011: w_dec = C_SYSTEM;
            default:    w_dec = C_ILLEGAL;
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_wb_sel   = 2'b00;
        w_pc_sel   = 2'b00;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_we    = imem_ready;
            end
            S_EXEC: begin
                if (r_cls == C_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = branch_taken ? 2'b01 : 2'b00;
                    w_retire = 1'b1;
                end else if (r_cls == C_FENCE) begin
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_cls == C_STORE);
                if (dmem_ready && r_cls == C_STORE) begin
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                case (r_cls)
                    C_LOAD:         w_wb_sel = 2'b01;
                    C_JAL, C_JALR:  w_wb_sel = 2'b10;
                    C_LUI:          w_wb_sel = 2'b11;
                    default:        w_wb_sel = 2'b00;
                endcase
                case (r_cls)
                    C_JAL:   w_pc_sel = 2'b01;
                    C_JALR:  w_pc_sel = 2'b10;
                    default: w_pc_sel = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cls     <= C_ALU;
            r_illegal <= 1'b0;
            r_count   <= 32'd0;
        end else begin
            if (w_retire)
                r_count <= r_count + 32'd1;
            case (r_state)
                S_FETCH:
                    if (imem_ready)
                        r_state <= S_DECODE;
                S_DECODE: begin
                    r_cls <= w_dec;
                    if (w_dec == C_ILLEGAL) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else if (w_dec == C_SYSTEM) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC:
                    case (r_cls)
                        C_ALU, C_LUI, C_AUIPC, C_JAL, C_JALR:
                            r_state <= S_WB;
                        C_LOAD, C_STORE:
                            r_state <= S_MEM;
                        C_BRANCH, C_FENCE:
                            r_state <= S_FETCH;
                        default:
                            r_state <= S_HALT;
                    endcase
                S_MEM:
                    if (dmem_ready)
                        r_state <= (r_cls == C_STORE) ? S_FETCH : S_WB;
                S_WB:
                    r_state <= S_FETCH;
                default:
                    r_state <= S_HALT;
            endcase
        end
    end

    // Reset gates every strobe and mux select in the same cycle.
    assign imem_req    = w_imem_req & ~rst;
    assign ir_we       = w_ir_we & ~rst;
    assign dmem_req    = w_dmem_req & ~rst;
    assign dmem_we     = w_dmem_we & ~rst;
    assign rf_we       = w_rf_we & ~rst;
    assign pc_we       = w_pc_we & ~rst;
    assign wb_sel      = rst ? 2'b00 : w_wb_sel;
    assign pc_sel      = rst ? 2'b00 : w_pc_sel;
    assign illegal     = r_illegal;
    assign halted      = (r_state == S_HALT);
    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expectations planned from the
// instruction class rules, directed scenarios plus a random stream.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] instr_count;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .illegal(illegal), .halted(halted), .state(state),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {
        K_ALU, K_LUI, K_AUIPC, K_LD, K_ST, K_BR,
        K_JAL, K_JALR, K_FEN, K_SYS, K_ILL
    } kind_t;

    typedef struct packed {
        logic       imr;
        logic       dmr;
        logic       bt;
        logic [2:0] st;
        logic       ireq;
        logic       irwe;
        logic       dreq;
        logic       dwe;
        logic       rfwe;
        logic       pcwe;
        logic [1:0] wbs;
        logic [1:0] pcs;
        logic       ret;
        logic       sill;
    } cyc_t;

    cyc_t        q[$];
    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] m_cnt  = 0;
    logic        m_ill  = 0;

    function automatic kind_t kind(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011: return K_ALU;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0001111: return K_FEN;
            7'b1110011: return K_SYS;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c     = '0;
        c.imr = 1'($urandom_range(1));
        c.dmr = 1'($urandom_range(1));
        c.bt  = 1'($urandom_range(1));
        c.st  = st;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plan(input logic [6:0] op, input int iw, input int dw,
                        input logic bt, input int hc);
        cyc_t  c;
        kind_t k;
        k = kind(op);
        for (int i = 0; i < iw; i++) begin
            c = mk(3'd0); c.imr = 1'b0; c.ireq = 1'b1;
            q.push_back(c);
        end
        c = mk(3'd0); c.imr = 1'b1; c.ireq = 1'b1; c.irwe = 1'b1;
        q.push_back(c);
        c = mk(3'd1); c.sill = (k == K_ILL);
        q.push_back(c);
        if (k == K_ILL || k == K_SYS) begin
            for (int i = 0; i < hc; i++) q.push_back(mk(3'd5));
            return;
        end
        c = mk(3'd2);
        if (k == K_BR || k == K_FEN) begin
            c.bt   = bt;
            c.pcwe = 1'b1;
            c.pcs  = (k == K_BR && bt) ? 2'b01 : 2'b00;
            c.ret  = 1'b1;
            q.push_back(c);
            return;
        end
        q.push_back(c);
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < dw; i++) begin
                c = mk(3'd3); c.dmr = 1'b0;
                c.dreq = 1'b1; c.dwe = (k == K_ST);
                q.push_back(c);
            end
            c = mk(3'd3); c.dmr = 1'b1;
            c.dreq = 1'b1; c.dwe = (k == K_ST);
            if (k == K_ST) begin
                c.pcwe = 1'b1; c.ret = 1'b1;
                q.push_back(c);
                return;
            end
            q.push_back(c);
        end
        c = mk(3'd4);
        c.rfwe = 1'b1; c.pcwe = 1'b1; c.ret = 1'b1;
        c.wbs  = (k == K_LD) ? 2'b01 :
                 (k == K_JAL || k == K_JALR) ? 2'b10 :
                 (k == K_LUI) ? 2'b11 : 2'b00;
        c.pcs  = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
        q.push_back(c);
    endtask

    task automatic run(input string tag, input logic [6:0] op,
                       input int lim);
        cyc_t c;
        int   n;
        n = 0;
        opcode = op;
        while (q.size() > 0 && n < lim) begin
            c = q.pop_front();
            rst          = 1'b0;
            imem_ready   = c.imr;
            dmem_ready   = c.dmr;
            branch_taken = c.bt;
            @(negedge clk);
            chk({tag, "_state"}, 32'(state), 32'(c.st));
            chk({tag, "_strobes"},
                32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}),
                32'({c.ireq, c.irwe, c.dreq, c.dwe, c.rfwe, c.pcwe}));
            chk({tag, "_sel"}, 32'({wb_sel, pc_sel}), 32'({c.wbs, c.pcs}));
            chk({tag, "_halted"}, 32'(halted), 32'(c.st == 3'd5));
            chk({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
            chk({tag, "_count"}, instr_count, m_cnt);
            @(posedge clk); #1;
            if (c.ret)  m_cnt = m_cnt + 32'd1;
            if (c.sill) m_ill = 1'b1;
            n++;
        end
        q.delete();
    endtask

    task automatic rst_phase(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rst          = 1'b1;
            imem_ready   = 1'($urandom_range(1));
            dmem_ready   = 1'($urandom_range(1));
            branch_taken = 1'($urandom_range(1));
            @(negedge clk);
            chk({tag, "_rst_strobes"},
                32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
                     wb_sel, pc_sel}), 32'd0);
            @(posedge clk); #1;
        end
        m_cnt = 0;
        m_ill = 1'b0;
        chk({tag, "_rst_state"}, 32'(state), 32'd0);
        chk({tag, "_rst_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_rst_count"}, instr_count, 32'd0);
        chk({tag, "_rst_halted"}, 32'(halted), 32'd0);
    endtask

    logic [6:0] ops [10] = '{
        7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
        7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111
    };

    initial begin
        rst = 1'b1; opcode = '0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        rst_phase("init", 2);

        plan(7'b0010011, 0, 0, 1'b0, 0); run("addi", 7'b0010011, 99);
        chk("addi_retired", instr_count, 32'd1);
        plan(7'b0000011, 1, 2, 1'b0, 0); run("lw", 7'b0000011, 99);
        plan(7'b1100011, 0, 0, 1'b1, 0); run("beq_t", 7'b1100011, 99);
        plan(7'b1100011, 0, 0, 1'b0, 0); run("beq_n", 7'b1100011, 99);
        plan(7'b1100111, 0, 0, 1'b0, 0); run("jalr", 7'b1100111, 99);
        plan(7'b0100011, 0, 1, 1'b0, 0); run("sw", 7'b0100011, 99);

        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            op = ops[$urandom_range(9)];
            plan(op, int'($urandom_range(2)), int'($urandom_range(3)),
                 1'($urandom_range(1)), 0);
            run("rand", op, 99);
        end
        chk("rand_count", instr_count, m_cnt);

        plan(7'b1110011, 0, 0, 1'b0, 4); run("ecall", 7'b1110011, 99);
        rst_phase("ecall", 1);

        plan(7'b0000000, 0, 0, 1'b0, 10); run("ill", 7'b0000000, 99);
        rst_phase("ill", 1);

        plan(7'b0100011, 0, 3, 1'b0, 0); run("sw_abort", 7'b0100011, 4);
        rst_phase("sw_abort", 1);

        plan(7'b0110111, 0, 0, 1'b0, 0); run("post_lui", 7'b0110111, 99);
        chk("post_count", instr_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
